// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: word width, transmitter state encoding, bit-timing helper.
package uart_tx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Clock cycles per line bit; integer division truncates toward zero.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side word handshake into the UART transmitter FIFO.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic [DATA_BITS-1:0] i_data_tx;
    logic                 i_valid_tx;
    logic                 o_ready_tx;

    modport master (output i_data_tx, output i_valid_tx, input  o_ready_tx);
    modport slave  (input  i_data_tx, input  i_valid_tx, output o_ready_tx);

endinterface

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and wrap-bit pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_next, rd_ptr_next;
    logic             push, pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Next pointer values, used both for the pointer registers and the flag lookahead.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (push) wr_ptr_next = wr_ptr + PTR_ONE;
        if (pop)  rd_ptr_next = rd_ptr + PTR_ONE;
    end

    // Pointers and flags; full when only the wrap bits differ, empty when pointers match.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            full   <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
            empty  <= (wr_ptr_next == rd_ptr_next);
        end
    end

    // Storage write port.
    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: input FIFO feeding a start/data/stop serialiser on an idle-high line.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    uart_tx_if.slave  bus,
    input  logic      i_enb_tx,
    output logic      o_data_tx,
    output logic      o_busy_tx
);

    localparam int                 CPB       = clks_per_bit(CLK_FREQ, BAUD);
    localparam int                 BAUD_W    = $clog2(CPB + 1);
    localparam int                 IDX_W     = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CPB - 1);
    localparam logic [BAUD_W-1:0]  BAUD_ONE  = BAUD_W'(1);
    localparam logic [IDX_W-1:0]   DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]   STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);

    tx_state_t            state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full, fifo_empty;
    logic                 bit_done, stop_done, pop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_en   (bus.i_valid_tx),
        .wr_data (bus.i_data_tx),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign bus.o_ready_tx = !fifo_full;

    // A new frame may only start from IDLE or at the very end of the last stop bit.
    assign bit_done  = (baud_cnt == BAUD_LAST);
    assign stop_done = (state == STOP) && bit_done && (bit_idx == STOP_LAST);
    assign pop       = !fifo_empty && i_enb_tx && ((state == IDLE) || stop_done);

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            o_data_tx <= 1'b1;
            o_busy_tx <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= START;
                        shift     <= fifo_rd_data;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        o_data_tx <= 1'b0;
                        o_busy_tx <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state     <= DATA;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        o_data_tx <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == DATA_LAST) begin
                            state     <= STOP;
                            bit_idx   <= '0;
                            o_data_tx <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + IDX_ONE;
                            o_data_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (pop) begin
                                // Back-to-back frame: no idle gap, busy stays high.
                                state     <= START;
                                shift     <= fifo_rd_data;
                                o_data_tx <= 1'b0;
                            end else begin
                                state     <= IDLE;
                                o_busy_tx <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_ONE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_data_tx <= 1'b1;
                    o_busy_tx <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random words checked against a frame-level line model.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int CF  = 1000;
    localparam int BD  = 100;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enb1, enb2, line1, line2, busy1, busy2;

    always #5 clk = ~clk;

    uart_tx_if bus1 ();
    uart_tx_if bus2 ();

    uart_tx #(.CLK_FREQ(CF), .BAUD(BD), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1),
        .i_enb_tx(enb1), .o_data_tx(line1), .o_busy_tx(busy1)
    );

    uart_tx #(.CLK_FREQ(CF), .BAUD(BD), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus2),
        .i_enb_tx(enb2), .o_data_tx(line2), .o_busy_tx(busy2)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_line(input int sel);
        return (sel != 0) ? line2 : line1;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy2 : busy1;
    endfunction

    // Drive one word for one cycle starting at the current negedge.
    task automatic push(input int sel, input logic [7:0] w);
        if (sel != 0) begin
            bus2.i_valid_tx = 1'b1; bus2.i_data_tx = w;
        end else begin
            bus1.i_valid_tx = 1'b1; bus1.i_data_tx = w;
        end
        @(negedge clk);
        bus1.i_valid_tx = 1'b0;
        bus2.i_valid_tx = 1'b0;
    endtask

    // Drive two words on consecutive cycles.
    task automatic push2(input int sel, input logic [7:0] a, input logic [7:0] b);
        if (sel != 0) begin
            bus2.i_valid_tx = 1'b1; bus2.i_data_tx = a;
            @(negedge clk);
            bus2.i_data_tx = b;
        end else begin
            bus1.i_valid_tx = 1'b1; bus1.i_data_tx = a;
            @(negedge clk);
            bus1.i_data_tx = b;
        end
        @(negedge clk);
        bus1.i_valid_tx = 1'b0;
        bus2.i_valid_tx = 1'b0;
    endtask

    // Compare the line cycle by cycle against the ideal frame for w; the current
    // negedge is frame cycle first_k (cycle 0 = first cycle of the start bit).
    task automatic expect_frame(input int sel, input logic [7:0] w, input int first_k, input string tag);
        int         stop_cyc = (sel != 0) ? 2 * CPB : CPB;
        int         len      = 9 * CPB + stop_cyc;
        int         bad_line = 0;
        int         bad_busy = 0;
        int         b;
        logic       exp_bit;
        logic [7:0] got      = 8'h00;
        for (int k = first_k; k < len; k++) begin
            b = k / CPB;
            if (b == 0)      exp_bit = 1'b0;
            else if (b <= 8) exp_bit = w[b-1];
            else             exp_bit = 1'b1;
            if (get_line(sel) !== exp_bit) bad_line++;
            if (get_busy(sel) !== 1'b1)    bad_busy++;
            if (b >= 1 && b <= 8 && (k % CPB) == CPB / 2) got[b-1] = get_line(sel);
            @(negedge clk);
        end
        check({tag, "_word"}, got, w);
        check({tag, "_bad_line_cycles"}, bad_line, 0);
        check({tag, "_bad_busy_cycles"}, bad_busy, 0);
    endtask

    // Look for a start bit within a bounded number of cycles.
    task automatic wait_start(input int sel, input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (get_line(sel) === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         seen;
        logic [7:0] w, w2;

        enb1 = 1'b0; enb2 = 1'b0;
        bus1.i_valid_tx = 1'b0; bus1.i_data_tx = '0;
        bus2.i_valid_tx = 1'b0; bus2.i_data_tx = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_line1", line1, 1);
        check("rst_busy1", busy1, 0);
        check("rst_ready1", bus1.o_ready_tx, 1);
        check("rst_line2", line2, 1);
        check("rst_busy2", busy2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame 0xA5 and first-transaction latency.
        enb1 = 1'b1;
        push(0, 8'hA5);
        check("t1_line_before_n1", line1, 1);
        check("t1_busy_before_n1", busy1, 0);
        @(negedge clk);
        check("t1_line_fall_n1", line1, 0);
        check("t1_busy_rise_n1", busy1, 1);
        expect_frame(0, 8'hA5, 0, "t1");
        check("t1_busy_end", busy1, 0);
        check("t1_line_end", line1, 1);

        // Back-to-back 0x00 then 0xFF: no idle cycles between frames.
        push2(0, 8'h00, 8'hFF);
        expect_frame(0, 8'h00, 0, "t2a");
        expect_frame(0, 8'hFF, 0, "t2b");
        check("t2_busy_end", busy1, 0);

        // Random single frames.
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom_range(0, 255));
            exp_q.push_back(w);
            push(0, w);
            @(negedge clk);
            expect_frame(0, exp_q.pop_front(), 0, "rnd");
        end

        // Disabled: fill past depth, fifth word dropped, line idle; then drain in order.
        enb1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = 8'($urandom_range(0, 255));
            check("t3_ready", bus1.o_ready_tx, (exp_q.size() < 4));
            bus1.i_valid_tx = 1'b1; bus1.i_data_tx = w;
            if (exp_q.size() < 4) exp_q.push_back(w);
            @(negedge clk);
        end
        bus1.i_valid_tx = 1'b0;
        check("t3_ready_full", bus1.o_ready_tx, 0);
        wait_start(0, 30, seen);
        check("t3_no_frame_disabled", seen, 0);
        check("t3_busy_disabled", busy1, 0);
        enb1 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) expect_frame(0, exp_q.pop_front(), 0, "t3");
        wait_start(0, 50, seen);
        check("t3_no_extra_frame", seen, 0);

        // Full FIFO: push during the pop cycle is rejected, next push accepted.
        enb1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom_range(0, 255));
            exp_q.push_back(w);
            push(0, w);
        end
        check("t4_ready_full", bus1.o_ready_tx, 0);
        enb1 = 1'b1;
        bus1.i_valid_tx = 1'b1; bus1.i_data_tx = 8'h3C;  // arrives while full: dropped
        @(negedge clk);
        check("t4_ready_rise", bus1.o_ready_tx, 1);
        check("t4_line_start", line1, 0);
        w2 = 8'($urandom_range(0, 255));
        bus1.i_data_tx = w2;
        exp_q.push_back(w2);
        @(negedge clk);
        bus1.i_valid_tx = 1'b0;
        expect_frame(0, exp_q.pop_front(), 1, "t4_first");
        for (int i = 0; i < 4; i++) expect_frame(0, exp_q.pop_front(), 0, "t4");
        wait_start(0, 50, seen);
        check("t4_no_extra_frame", seen, 0);

        // Enable dropped in the middle of data bit 3.
        w  = 8'($urandom_range(0, 255));
        w2 = 8'($urandom_range(0, 255));
        push2(0, w, w2);
        fork
            expect_frame(0, w, 0, "t5");
            begin
                repeat (45) @(negedge clk);
                enb1 = 1'b0;
            end
        join
        wait_start(0, 60, seen);
        check("t5_no_frame_after_disable", seen, 0);
        check("t5_busy_idle", busy1, 0);
        check("t5_ready", bus1.o_ready_tx, 1);
        enb1 = 1'b1;
        @(negedge clk);
        expect_frame(0, w2, 0, "t5_resume");

        // Reset in the middle of a data bit: line high, busy low at once; FIFO discarded.
        push2(0, 8'h00, 8'($urandom_range(0, 255)));
        repeat (35) @(negedge clk);
        check("t6_line_low_pre_reset", line1, 0);
        rst_n = 1'b0;
        #1;
        check("t6_async_line", line1, 1);
        check("t6_async_busy", busy1, 0);
        check("t6_async_ready", bus1.o_ready_tx, 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start(0, 150, seen);
        check("t6_no_frame_after_reset", seen, 0);
        check("t6_busy_after_reset", busy1, 0);

        // Two stop bits: stop held 20 cycles, then back-to-back start.
        enb2 = 1'b1;
        w  = 8'($urandom_range(0, 255));
        w2 = 8'($urandom_range(0, 255));
        push2(1, w, w2);
        expect_frame(1, w, 0, "t7a");
        expect_frame(1, w2, 0, "t7b");
        check("t7_busy_end", busy2, 0);
        check("t7_line_end", line2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
